bcd_step_sequencer: RTL and testbench
=====================================

BCD_STEP_SEQUENCER -- requirements
Module: bcd_step_sequencer

Interface
REQ-001 Parameter: TICK_DIV, default 50_000_000, CLOCK_50 cycles per count tick (legal range 2..2^26).
REQ-002 Port: CLOCK_50  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  level, sampled each cycle; requests counting.
REQ-005 Port: stop  in  1  level, sampled each cycle; requests pause.
REQ-006 Port: step2  in  1  step select: 0 = +1 per tick, 1 = +2 per tick.
REQ-007 Port: load  in  1  one-cycle request to preset the count.
REQ-008 Port: load_val  in  8  preset value {tens[3:0], ones[3:0]}, BCD.
REQ-009 Port: tens  out  4  registered BCD tens digit.
REQ-010 Port: ones  out  4  registered BCD ones digit.
REQ-011 Port: running  out  1  high while in state RUN.
REQ-012 Port: wrap  out  1  one-cycle pulse when the count passes from 9x through 00.
REQ-013 Port: load_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-014 FSM states: IDLE, RUN, HOLD; running = (state == RUN).
REQ-015 Transitions: IDLE/HOLD -> RUN on start=1 and stop=0; RUN -> HOLD on stop=1; all other cases hold state.
REQ-016 start and stop both high: stop wins; RUN goes to HOLD, IDLE and HOLD stay put.
REQ-017 Prescaler counts 0..TICK_DIV-1 in RUN only; it is cleared on every entry to RUN and held at 0 outside RUN.
REQ-018 A tick occurs in the cycle where the prescaler equals TICK_DIV-1; the count updates on that same edge, so the first update falls TICK_DIV cycles after entry to RUN.
REQ-019 On a tick: ones <= (ones + step) mod 10, where step = 2 if step2 else 1; carry = (ones + step >= 10).
REQ-020 On carry: tens <= (tens + 1) mod 10; if tens was 9, assert wrap for exactly that cycle.
REQ-021 Ones transitions at a tick: step 2 from ones=9 gives ones=1 with carry; step 2 from ones=8 gives ones=0 with carry.
REQ-022 step2 is sampled only in the tick cycle; changes between ticks have no effect on the count.
REQ-023 load is honoured only in IDLE or HOLD, and only when both digits of load_val are <= 9; the count takes load_val on the next edge.
REQ-024 load with either digit > 9 (in IDLE or HOLD): count unchanged and load_err pulses for one cycle.
REQ-025 load in RUN is ignored silently: no count change, no load_err.
REQ-026 load and start in the same cycle from IDLE/HOLD: the load is applied and the state enters RUN, with the prescaler cleared.
REQ-027 tens and ones are always valid BCD (0..9) in every state.

Reset
REQ-028 reset=1 at a rising edge forces state=IDLE, tens=0, ones=0, prescaler=0, wrap=0 and load_err=0, and therefore running=0.
REQ-029 reset overrides start, stop, load and any pending tick in the same cycle, including reset asserted mid-RUN.
REQ-030 After reset deasserts, the block stays in IDLE until a valid start.

Structure
REQ-031 The shared package holds: FSM state encoding (2 bits), BCD digit width (4), the TICK_DIV default, and the BCD maximum constant 9.
REQ-032 One combinational sub-module, bcd_digit_step: inputs a digit and step2; outputs the next digit and carry; instantiated once for ones.
REQ-033 The tens +1 mod 10 update is inline; there are no other sub-modules.

Verification (TICK_DIV=4)
REQ-034 Reset, load_val=8'h37 with load, start held, step2=0, run 12 cycles -> count reads 37, 38, 39, 40 at cycles 4, 8, 12 after start; running=1.
REQ-035 From 98 with step2=1 -> next tick gives 00 with a single-cycle wrap; the following tick gives 02.
REQ-036 In HOLD, load_val=8'h5A with load -> count unchanged and load_err pulses for 1 cycle; load in RUN -> no change and no load_err.
REQ-037 In RUN, start=stop=1 -> state HOLD and the count frozen for 20 cycles; then start alone -> first tick occurs 4 cycles later.
REQ-038 reset asserted in the tick cycle at count 19 -> next cycle count=00, state IDLE, wrap=0.

Source files
------------

// File: rtl/bcd_step_sequencer_pkg.sv
// bcd_step_sequencer_pkg: shared FSM encoding and BCD constants for the step sequencer
package bcd_step_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  localparam int DIGIT_W = 4;
  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: advances one BCD digit by 1 or 2 and reports the decimal carry
module bcd_digit_step
  import bcd_step_sequencer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               step2_i,
  output logic [DIGIT_W-1:0] next_o,
  output logic               carry_o
);
  logic [DIGIT_W-1:0] sum;
  // A legal digit plus 2 peaks at 11, so four bits never overflow
  always_comb begin
    sum = digit_i + (step2_i ? 4'd2 : 4'd1);
    carry_o = sum > BCD_MAX;
    next_o = carry_o ? sum - 4'd10 : sum;
  end
endmodule

// File: rtl/bcd_step_sequencer.sv
// bcd_step_sequencer: two-digit BCD counter advancing by 1 or 2 on each prescaled tick
module bcd_step_sequencer
  import bcd_step_sequencer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               step2,
  input  logic               load,
  input  logic [7:0]         load_val,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               running,
  output logic               wrap,
  output logic               load_err
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DIGIT_W-1:0] tens_q, tens_d, ones_q, ones_d, ones_nx;
  logic wrap_q, wrap_d, err_q, err_d, tick, carry, valid, ld_ok, ld_req;
  bcd_digit_step u_ones (
    .digit_i (ones_q),
    .step2_i (step2),
    .next_o  (ones_nx),
    .carry_o (carry)
  );
  always_comb begin
    tick = state_q == RUN && pre_q == LAST;
    valid = load_val[7:4] <= BCD_MAX && load_val[3:0] <= BCD_MAX;
    ld_req = load && state_q != RUN;
    ld_ok = ld_req && valid;
    state_d = state_q == RUN ? (stop ? HOLD : RUN) : (start && !stop ? RUN : state_q);
    // Prescaler restarts from 0 on every entry to RUN
    pre_d = state_q == RUN && state_d == RUN ? (tick ? '0 : pre_q + 1'b1) : '0;
    ones_d = ld_ok ? load_val[3:0] : tick ? ones_nx : ones_q;
    tens_d = ld_ok ? load_val[7:4] : tick && carry ? (tens_q == BCD_MAX ? '0 : tens_q + 1'b1) : tens_q;
    wrap_d = tick && carry && tens_q == BCD_MAX;
    err_d = ld_req && !valid;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      wrap_q <= wrap_d;
      err_q <= err_d;
    end
  end
  assign tens = tens_q;
  assign ones = ones_q;
  assign running = state_q == RUN;
  assign wrap = wrap_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_step_sequencer.sv
// tb_bcd_step_sequencer: directed scoreboard bench for bcd_step_sequencer with TICK_DIV=4
module tb_bcd_step_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, step2 = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] tens, ones;
  logic running, wrap, load_err;
  int n_vec = 0, n_err = 0;
  typedef struct {
    string tag;
    logic [10:0] v;
  } exp_t;
  exp_t sb[$];

  bcd_step_sequencer #(.TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .step2    (step2),
    .load     (load),
    .load_val (load_val),
    .tens     (tens),
    .ones     (ones),
    .running  (running),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ev(input logic r, input logic w, input logic e, input logic [7:0] bcd);
    return {r, w, e, bcd};
  endfunction

  task automatic push(input string t, input logic [10:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check();
    exp_t e;
    logic [10:0] obs;
    obs = {running, wrap, load_err, tens, ones};
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s observed={run,wrap,err,bcd}=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push("reset", ev(0, 0, 0, 8'h00)); step(1); check();
    reset = 0; load = 1; load_val = 8'h37; start = 1;
    push("load_start", ev(1, 0, 0, 8'h37)); step(1); check();
    load = 0;
    push("pre_tick", ev(1, 0, 0, 8'h37)); step(3); check();
    push("tick1", ev(1, 0, 0, 8'h38)); step(1); check();
    push("tick2", ev(1, 0, 0, 8'h39)); step(4); check();
    push("tick3", ev(1, 0, 0, 8'h40)); step(4); check();
    start = 0; stop = 1;
    push("hold", ev(0, 0, 0, 8'h40)); step(1); check();
    stop = 0; load = 1; load_val = 8'h98;
    push("load98", ev(0, 0, 0, 8'h98)); step(1); check();
    load = 0; step2 = 1; start = 1;
    push("rerun", ev(1, 0, 0, 8'h98)); step(1); check();
    push("pre_wrap", ev(1, 0, 0, 8'h98)); step(3); check();
    push("wrap", ev(1, 1, 0, 8'h00)); step(1); check();
    push("wrap_clear", ev(1, 0, 0, 8'h00)); step(1); check();
    push("after_wrap", ev(1, 0, 0, 8'h02)); step(3); check();
    push("step2_sampled", ev(1, 0, 0, 8'h03));
    step2 = 0; step(1); step2 = 1; step(1); step2 = 0; step(2); check();
    load = 1; load_val = 8'h55;
    push("load_in_run", ev(1, 0, 0, 8'h03)); step(1); check();
    load = 0; start = 1; stop = 1;
    push("both_hold", ev(0, 0, 0, 8'h03)); step(1); check();
    push("frozen", ev(0, 0, 0, 8'h03)); step(20); check();
    start = 0; stop = 0; load = 1; load_val = 8'h5A;
    push("load_err", ev(0, 0, 1, 8'h03)); step(1); check();
    load = 0;
    push("err_clear", ev(0, 0, 0, 8'h03)); step(1); check();
    start = 1;
    push("restart", ev(1, 0, 0, 8'h03)); step(1); check();
    push("restart_pre", ev(1, 0, 0, 8'h03)); step(3); check();
    push("restart_tick", ev(1, 0, 0, 8'h04)); step(1); check();
    start = 0; stop = 1;
    push("hold2", ev(0, 0, 0, 8'h04)); step(1); check();
    stop = 0; load = 1; load_val = 8'h19; start = 1;
    push("load19_start", ev(1, 0, 0, 8'h19)); step(1); check();
    load = 0;
    push("pre_reset", ev(1, 0, 0, 8'h19)); step(3); check();
    reset = 1;
    push("reset_mid_run", ev(0, 0, 0, 8'h00)); step(1); check();
    reset = 0; start = 0;
    push("stay_idle", ev(0, 0, 0, 8'h00)); step(3); check();
    load = 1; load_val = 8'hA3;
    push("load_err_tens", ev(0, 0, 1, 8'h00)); step(1); check();
    load = 0; start = 1; stop = 1;
    push("idle_both", ev(0, 0, 0, 8'h00)); step(2); check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
